// File: rtl/step_sequencer_pkg.sv
// Shared constants for the step sequencer: FSM encodings,
// default step clamp and step counter width, plus a clamp helper.
package step_sequencer_pkg;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PULSE_HI = 2'd1;
  localparam logic [1:0] S_PULSE_LO = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam int MAX_STEPS_DEF = 10;
  localparam int STEP_CNT_W    = 4;

  function automatic logic [STEP_CNT_W-1:0] clamp_steps(
    input logic [STEP_CNT_W-1:0] s,
    input logic [STEP_CNT_W-1:0] mx
  );
    return (s > mx) ? mx : s;
  endfunction

endpackage

// File: rtl/step_sequencer_timer.sv
// Phase timer: counts enabled cycles from 0 and flags the last one.
// Ports: clk, rst (sync high), clear, en in; expired out (comb).
module step_phase_timer #(
  parameter int LIMIT = 2,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Fires on the LIMIT-th enabled cycle; the count holds there
  // rather than wrapping until the owner clears it.
  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (en && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: latches a clamped step count on start and emits
// that many fixed-width pulses at a fixed period.
// Ports: clk, rst, start, abort, steps_in[3:0] in;
//        step_out, busy, done, remaining[3:0] out (all registered).
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int PULSE_CYC  = 50_000_000,
  parameter int PERIOD_CYC = 100_000_000,
  parameter int MAX_STEPS  = MAX_STEPS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STEP_CNT_W-1:0] steps_in,
  output logic                  step_out,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_CNT_W-1:0] remaining
);

  localparam int TW     = $clog2(PERIOD_CYC + 1);
  localparam int LO_CYC = PERIOD_CYC - PULSE_CYC;

  logic [1:0]            state_q, state_d;
  logic                  step_q, step_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [STEP_CNT_W-1:0] rem_q, rem_d;
  logic                  hi_en, lo_en;
  logic                  hi_exp, lo_exp;

  assign hi_en = (state_q == S_PULSE_HI);
  assign lo_en = (state_q == S_PULSE_LO);

  // Each timer is held clear outside its own phase, so it always
  // enters the phase at zero.
  step_phase_timer #(.LIMIT(PULSE_CYC), .W(TW)) u_hi (
    .clk     (clk),
    .rst     (rst),
    .clear   (!hi_en),
    .en      (hi_en),
    .expired (hi_exp)
  );

  step_phase_timer #(.LIMIT(LO_CYC), .W(TW)) u_lo (
    .clk     (clk),
    .rst     (rst),
    .clear   (!lo_en),
    .en      (lo_en),
    .expired (lo_exp)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && steps_in != '0) begin
          state_d = S_PULSE_HI;
          step_d  = 1'b1;
          rem_d   = clamp_steps(steps_in,
                                STEP_CNT_W'(MAX_STEPS));
        end
      end
      S_PULSE_HI: begin
        if (abort) begin
          state_d = S_IDLE;
          step_d  = 1'b0;
          rem_d   = '0;
        end else if (hi_exp) begin
          state_d = S_PULSE_LO;
          step_d  = 1'b0;
          rem_d   = rem_q - 1'b1;
        end
      end
      S_PULSE_LO: begin
        if (abort) begin
          state_d = S_IDLE;
          step_d  = 1'b0;
          rem_d   = '0;
        end else if (lo_exp) begin
          if (rem_q != '0) begin
            state_d = S_PULSE_HI;
            step_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

  assign step_out  = step_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule
